// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON host-side block suppliers.
package ascon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    READY
  } ad_sup_state_t;

  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int AD_BLOCK_BYTES = 8;

  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    logic [3:0] max_l;
    max_l = 4'(AD_BLOCK_BYTES);
    return (l > max_l) ? max_l : l;
  endfunction

endpackage

// File: rtl/ad_pad_gen.sv
// ASCON 10* pad lane: byte-lane mask at position len, empty for a full block.
module ad_pad_gen
  import ascon_pkg::*;
(
  input  logic [3:0]  len,
  output logic [63:0] pad_mask,
  output logic        pad_en
);

  always_comb begin
    pad_en   = (len < 4'(AD_BLOCK_BYTES));
    pad_mask = '0;
    if (pad_en) begin
      pad_mask = {8'hff, 56'd0} >> {len[2:0], 3'b000};
    end
  end

endmodule

// File: rtl/ad_block_supplier.sv
// Packs host AD bytes into padded 64-bit ASCON blocks and
// holds each block until the core reads it.
module ad_block_supplier
  import ascon_pkg::*;
(
  input  logic        clk,
  input  logic        RST,
  input  logic        clear,
  input  logic        block_request,
  input  logic [3:0]  datalen,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        AD_read,
  output logic [63:0] block_out,
  output logic        block_valid,
  output logic [4:0]  ad_count
);

  ad_sup_state_t state_q, state_d;
  logic [63:0] block_q, block_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  len_q, len_d;
  logic [4:0]  ad_count_q, ad_count_d;

  logic [3:0]  req_len;
  logic [3:0]  pad_len;
  logic [63:0] pad_mask;
  logic [63:0] pad_lane;
  logic [63:0] byte_lane;
  logic        pad_en;
  logic        xfer;
  logic        start;

  assign req_len   = clamp_len(datalen);
  assign byte_ready = (state_q == FILL) && (idx_q < len_q);
  assign xfer      = byte_valid & byte_ready;
  assign start     = block_request &
                     ((state_q == IDLE) |
                      ((state_q == READY) & AD_read));
  // Pad lane follows the latched length while filling,
  // otherwise the length being requested now.
  assign pad_len   = (state_q == FILL) ? len_q : req_len;
  assign pad_lane  = pad_mask & {8{PAD_BYTE}};
  assign byte_lane = {byte_in, 56'd0} >> {idx_q[2:0], 3'b000};

  ad_pad_gen u_pad (
    .len      (pad_len),
    .pad_mask (pad_mask),
    .pad_en   (pad_en)
  );

  always_comb begin
    state_d    = state_q;
    block_d    = block_q;
    idx_d      = idx_q;
    len_d      = len_q;
    ad_count_d = ad_count_q;
    unique case (state_q)
      IDLE, READY: begin
        if (start) begin
          len_d   = req_len;
          idx_d   = '0;
          block_d = '0;
          if (req_len == 4'd0) begin
            state_d = READY;
            block_d = pad_lane;
          end else begin
            state_d = FILL;
          end
        end else if ((state_q == READY) && AD_read) begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (xfer) begin
          block_d = block_q | byte_lane;
          idx_d   = idx_q + 4'd1;
          if (ad_count_q != 5'd31) begin
            ad_count_d = ad_count_q + 5'd1;
          end
          if (idx_d == len_q) begin
            state_d = READY;
            if (pad_en) begin
              block_d = block_d | pad_lane;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST | clear) begin
      state_q    <= IDLE;
      block_q    <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      ad_count_q <= '0;
    end else begin
      state_q    <= state_d;
      block_q    <= block_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      ad_count_q <= ad_count_d;
    end
  end

  assign block_out   = block_q;
  assign block_valid = (state_q == READY);
  assign ad_count    = ad_count_q;

endmodule

// File: tb/tb_ad_block_supplier.sv
// Scoreboard bench for ad_block_supplier: expected blocks queued
// at request time, compared when block_valid appears.
module tb_ad_block_supplier;

  logic        clk = 1'b0;
  logic        RST;
  logic        clear;
  logic        block_request;
  logic [3:0]  datalen;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        AD_read;
  logic [63:0] block_out;
  logic        block_valid;
  logic [4:0]  ad_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic [63:0] exp_q[$];

  ad_block_supplier dut (
    .clk           (clk),
    .RST           (RST),
    .clear         (clear),
    .block_request (block_request),
    .datalen       (datalen),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .AD_read       (AD_read),
    .block_out     (block_out),
    .block_valid   (block_valid),
    .ad_count      (ad_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model_block(
    input int len, input logic [7:0] d [8]);
    logic [63:0] b;
    b = '0;
    for (int i = 0; i < len; i++) b[63-8*i -: 8] = d[i];
    if (len < 8) b[63-8*len -: 8] = 8'h80;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [3:0] dl,
                         input logic [63:0] exp_blk);
    block_request = 1'b1;
    datalen = dl;
    exp_q.push_back(exp_blk);
    step();
    block_request = 1'b0;
    datalen = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_in = b;
    while (!byte_ready && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_byte: byte_ready=%b required 1 for byte %02h",
               byte_ready, b);
    end else begin
      step();
      if (exp_count < 31) exp_count++;
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_block(input string name);
    int n;
    logic [63:0] exp;
    n = 0;
    while (!block_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: block seen=%h but scoreboard empty",
               name, block_out);
    end else begin
      exp = exp_q.pop_front();
      if (block_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s: block_valid=%b required 1 (timeout)",
                 name, block_valid);
      end else if (block_out !== exp) begin
        errors++;
        $display("FAIL %s: block_out=%h required %h",
                 name, block_out, exp);
      end
    end
  endtask

  task automatic check_count(input string name);
    checks++;
    if (ad_count !== exp_count[4:0]) begin
      errors++;
      $display("FAIL %s: ad_count=%0d required %0d",
               name, ad_count, exp_count);
    end
  endtask

  task automatic consume(input string name);
    AD_read = 1'b1;
    step();
    AD_read = 1'b0;
    checks++;
    if (block_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: block_valid=%b required 0 after AD_read",
               name, block_valid);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    block_request = 1'b1;
    datalen = 4'd0;
    step();
    step();
    RST = 1'b0;
    block_request = 1'b0;
    step();
    checks++;
    if (block_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: block_valid=%b required 0", block_valid);
    end
    checks++;
    if (block_out !== 64'd0) begin
      errors++;
      $display("FAIL reset_block: block_out=%h required 0", block_out);
    end
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: byte_ready=%b required 0", byte_ready);
    end
    check_count("reset_count");
  endtask

  task automatic test_full_block();
    request(4'd8, 64'h0102030405060708);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    checks++;
    if (block_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_latency: block_valid=%b required 1", block_valid);
    end
    check_block("full_block");
    check_count("full_count");
    consume("full_consume");
  endtask

  task automatic test_partial();
    request(4'd3, 64'hAABBCC8000000000);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL partial_ready: byte_ready=%b required 0", byte_ready);
    end
    check_block("partial_block");
    check_count("partial_count");
    consume("partial_consume");
  endtask

  task automatic test_pad_only();
    request(4'd0, 64'h8000000000000000);
    checks++;
    if (block_valid !== 1'b1) begin
      errors++;
      $display("FAIL pad_latency: block_valid=%b required 1", block_valid);
    end
    check_block("pad_block");
    check_count("pad_count");
  endtask

  task automatic test_back_to_back();
    AD_read = 1'b1;
    block_request = 1'b1;
    datalen = 4'd2;
    exp_q.push_back(64'h1122800000000000);
    step();
    AD_read = 1'b0;
    block_request = 1'b0;
    checks++;
    if (byte_ready !== 1'b1 || block_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_idle: ready=%b valid=%b required 1 0",
               byte_ready, block_valid);
    end
    send_byte(8'h11);
    send_byte(8'h22);
    check_block("b2b_block");
    check_count("b2b_count");
    AD_read = 1'b1;
    block_request = 1'b1;
    datalen = 4'd0;
    exp_q.push_back(64'h8000000000000000);
    step();
    AD_read = 1'b0;
    block_request = 1'b0;
    checks++;
    if (block_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pad_stay: block_valid=%b required 1", block_valid);
    end
    check_block("b2b_pad_block");
    consume("b2b_consume");
  endtask

  task automatic test_clamp_backpressure();
    logic [7:0] d [8];
    for (int i = 0; i < 8; i++) d[i] = 8'hC0 + 8'(i);
    request(4'd15, model_block(8, d));
    for (int i = 0; i < 8; i++) begin
      byte_valid = 1'b0;
      step();
      if (i == 3) begin
        AD_read = 1'b1;
        block_request = 1'b1;
        datalen = 4'd0;
        step();
        AD_read = 1'b0;
        block_request = 1'b0;
        checks++;
        if (byte_ready !== 1'b1 || block_valid !== 1'b0) begin
          errors++;
          $display("FAIL fill_ignore: ready=%b valid=%b required 1 0",
                   byte_ready, block_valid);
        end
      end
      send_byte(d[i]);
    end
    byte_valid = 1'b1;
    byte_in = 8'hFF;
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL clamp_ready: byte_ready=%b required 0", byte_ready);
    end
    step();
    step();
    byte_valid = 1'b0;
    check_block("clamp_block");
    check_count("clamp_count");
    consume("clamp_consume");
  endtask

  task automatic test_mid_fill_clear();
    block_request = 1'b1;
    datalen = 4'd8;
    step();
    block_request = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i));
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_count = 0;
    checks++;
    if (block_valid !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_flags: valid=%b ready=%b required 0 0",
               block_valid, byte_ready);
    end
    checks++;
    if (block_out !== 64'd0) begin
      errors++;
      $display("FAIL clear_block: block_out=%h required 0", block_out);
    end
    check_count("clear_count");
    request(4'd1, 64'h5A80000000000000);
    send_byte(8'h5A);
    check_block("after_clear_block");
    check_count("after_clear_count");
    consume("after_clear_consume");
  endtask

  task automatic test_saturation();
    logic [7:0] d [8];
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom_range(0, 255));
      request(4'd8, model_block(8, d));
      for (int i = 0; i < 8; i++) send_byte(d[i]);
      check_block("sat_block");
      consume("sat_consume");
    end
    check_count("sat_count");
  endtask

  initial begin
    RST = 1'b1;
    clear = 1'b0;
    block_request = 1'b0;
    datalen = '0;
    byte_in = '0;
    byte_valid = 1'b0;
    AD_read = 1'b0;
    test_reset();
    test_full_block();
    test_partial();
    test_pad_only();
    test_back_to_back();
    test_clamp_backpressure();
    test_mid_fill_clear();
    test_saturation();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad_block_supplier.md
Name: ad_block_supplier

Overview:
- Responder side of the associated-data block interface. It answers the AD block controller's block requests.
- Assembles up to 8 bytes from a byte-serial host stream into one 64-bit ASCON AD block. It applies ASCON 10* padding, then holds the block until the permutation datapath consumes it with AD_read.
- Sits between the host input FIFO and the AD absorb path of the ASCON core.

Parameters:
- BLOCK_BYTES, 8, bytes per AD block. Fixed at 8 for ASCON-128; other values are unsupported.
- PAD_BYTE, 8'h80, padding byte placed immediately after the last data byte.

Ports:
- clk  in  1  system clock
- RST  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush. Same effect as RST on state and outputs; higher priority than every other input.
- block_request  in  1  start assembling a new block. Sampled in IDLE and in READY together with AD_read.
- datalen  in  4  valid data bytes for the requested block, 0..8. Sampled with block_request; values >8 clamp to 8.
- byte_in  in  8  host data byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  supplier accepts byte_in this cycle
- AD_read  in  1  core consumes block_out this cycle
- block_out  out  64  assembled, padded block, big-endian (byte 0 in [63:56])
- block_valid  out  1  block_out holds a complete block
- ad_count  out  5  total data bytes accepted since reset/clear. Saturates at 31.

Behaviour:
- Reset/clear:
  - state=IDLE; block_out=0, block_valid=0, byte_ready=0, ad_count=0.
  - Byte counter and latched length are set to 0.
  - Any partially filled block is discarded.
- States: IDLE, FILL, READY.
- IDLE:
  - byte_ready=0, block_valid=0.
  - On block_request, latch len = min(datalen, 8), clear block_out and byte counter idx.
  - If len=0, go to READY and set block_out[63:56]=PAD_BYTE, rest zero. Otherwise go to FILL.
- FILL:
  - byte_ready = (idx < len).
  - A byte transfers when byte_valid & byte_ready: byte_in is written to byte lane idx (bits [63-8*idx -: 8]); idx increments; ad_count increments (saturating).
  - When the transfer fills the last byte (idx = len-1), the next state is READY.
  - In the same edge, if len<8, lane len is written with PAD_BYTE and lanes above len stay zero. If len=8, no padding is applied; the caller requests a separate datalen=0 block for the pad.
- READY:
  - block_valid=1, byte_ready=0. block_out is stable until consumed.
  - AD_read & ~block_request: go to IDLE; block_valid falls next cycle.
  - AD_read & block_request: consume the block and latch the new datalen in the same cycle, then go to FILL, or stay in READY for len=0 with the new pad-only block. No idle bubble.
  - block_request without AD_read: ignored.
- AD_read outside READY: ignored.
- block_request while in FILL: ignored. The current block completes first.
- Latency:
  - block_valid rises on the clock edge that accepts the final byte, so it is visible the next cycle.
  - For len=0, block_valid is visible one cycle after block_request.
- byte_valid with byte_ready=0: no transfer and no state change; the host must hold the byte.
- RST or clear asserted in any state returns to IDLE on that edge. Requests in the same cycle are dropped.

Decomposition:
- ascon_pkg gets:
  - the state enum ad_sup_state_t {IDLE, FILL, READY}
  - localparam PAD_BYTE = 8'h80
  - localparam AD_BLOCK_BYTES = 8
- Optional sub-module ad_pad_gen: combinational; takes len (4b) and produces the 64-bit pad mask plus pad-byte position. It is shared later with the plaintext supplier.
- Byte-lane write logic and the FSM stay in ad_block_supplier.

Test Plan:
- Full block: RST, then block_request with datalen=8, then bytes 01..08 on consecutive cycles.
  - Expect block_valid one cycle after byte 08, block_out=64'h0102030405060708, ad_count=8.
  - AD_read drops block_valid the next cycle.
- Partial block: datalen=3, bytes AA BB CC.
  - Expect block_out=64'hAABBCC8000000000, and byte_ready=0 after the third byte.
- Pad-only block: block_request with datalen=0 in IDLE.
  - Expect block_valid next cycle, block_out=64'h8000000000000000, ad_count unchanged.
- Back-to-back: in READY assert AD_read and block_request (datalen=2) together, then bytes 11 22.
  - Expect no IDLE cycle and block_out=64'h1122800000000000.
- Backpressure and clamp:
  - datalen=15 with byte_valid toggling: expect len clamped to 8, only 8 bytes accepted, byte_ready=0 for extra bytes.
  - AD_read while in FILL: expect no effect.
- Mid-fill reset: datalen=8, 4 bytes accepted, then clear for 1 cycle.
  - Expect IDLE, block_out=0, ad_count=0, block_valid=0.
  - A following datalen=1 request with byte 5A gives 64'h5A80000000000000.
